// File: rtl/best_result_reporter.sv
// best_result_reporter: tracks the global best bits-off score from the hashing core.
// On every strict improvement it sends a framed report as a byte-wide valid/ready stream.
// Frame layout: header, {6'b0, score[9:8]}, score[7:0], then the nonce MSB-first.
// Optional feature: define REPORTER_CHECKSUM_EN to append one more byte.
// That byte is the XOR of every earlier byte in the frame, header included.
module best_result_reporter #(
  parameter int unsigned NONCE_BYTES = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [8*NONCE_BYTES-1:0] best_nonce_i,
  input  logic [9:0]               best_bits_off_i,
  input  logic                     clear_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic                     busy_o,
  output logic [9:0]               global_best_o,
  output logic [15:0]              frames_sent_o
);

  localparam int unsigned NONCE_W   = 8 * NONCE_BYTES;
`ifdef REPORTER_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 4 + NONCE_BYTES;
`else
  localparam int unsigned FRAME_LEN = 3 + NONCE_BYTES;
`endif
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned SHF_W     = 16 + NONCE_W;

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic [9:0]           gbest_q, gbest_d;
  logic                 pend_q, pend_d;
  logic [9:0]           pend_score_q, pend_score_d;
  logic [NONCE_W-1:0]   pend_nonce_q, pend_nonce_d;
  logic [SHF_W-1:0]     shf_q, shf_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [7:0]           byte_q, byte_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [15:0]          frames_q, frames_d;
`ifdef REPORTER_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif
  logic                 improve;

  assign improve       = best_bits_off_i < gbest_q;
  assign byte_o        = byte_q;
  assign byte_valid_o  = valid_q;
  assign busy_o        = busy_q;
  assign global_best_o = gbest_q;
  assign frames_sent_o = frames_q;

  // Next-state: best tracking, one-deep pending snapshot, frame serializer
  always_comb begin
    state_d      = state_q;
    gbest_d      = gbest_q;
    pend_d       = pend_q;
    pend_score_d = pend_score_q;
    pend_nonce_d = pend_nonce_q;
    shf_d        = shf_q;
    idx_d        = idx_q;
    byte_d       = byte_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    frames_d     = frames_q;
`ifdef REPORTER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    // clear beats a simultaneous improvement
    if (clear_i) begin
      gbest_d = 10'h3FF;
      pend_d  = 1'b0;
    end else if (improve) begin
      gbest_d      = best_bits_off_i;
      pend_d       = 1'b1;
      pend_score_d = best_bits_off_i;
      pend_nonce_d = best_nonce_i;
    end

    case (state_q)
      IDLE: begin
        if (pend_q && !clear_i) begin
          state_d = SEND;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          byte_d  = HEADER_BYTE;
          idx_d   = '0;
          shf_d   = {6'b0, pend_score_q, pend_nonce_q};
`ifdef REPORTER_CHECKSUM_EN
          csum_d  = '0;
`endif
          // a same-edge improvement keeps its own fresh pending snapshot
          if (!improve) pend_d = 1'b0;
        end
      end
      SEND: begin
        if (valid_q && byte_ready_i) begin
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            frames_d = frames_q + 16'd1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
`ifdef REPORTER_CHECKSUM_EN
            csum_d = csum_q ^ byte_q;
            if (idx_q == IDX_W'(FRAME_LEN - 2)) begin
              byte_d = csum_q ^ byte_q;
            end else begin
              byte_d = shf_q[SHF_W-1 -: 8];
              shf_d  = shf_q << 8;
            end
`else
            byte_d = shf_q[SHF_W-1 -: 8];
            shf_d  = shf_q << 8;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      gbest_q      <= 10'h3FF;
      pend_q       <= 1'b0;
      pend_score_q <= '0;
      pend_nonce_q <= '0;
      shf_q        <= '0;
      idx_q        <= '0;
      byte_q       <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frames_q     <= '0;
`ifdef REPORTER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gbest_q      <= gbest_d;
      pend_q       <= pend_d;
      pend_score_q <= pend_score_d;
      pend_nonce_q <= pend_nonce_d;
      shf_q        <= shf_d;
      idx_q        <= idx_d;
      byte_q       <= byte_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frames_q     <= frames_d;
`ifdef REPORTER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_best_result_reporter.sv
// Bench for best_result_reporter: frame-level reference model plus directed scenarios.
module tb_best_result_reporter;
  localparam int NB = 32;
`ifdef REPORTER_CHECKSUM_EN
  localparam int LEN = NB + 4;
`else
  localparam int LEN = NB + 3;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [8*NB-1:0]  best_nonce_i;
  logic [9:0]       best_bits_off_i;
  logic             clear_i;
  logic [7:0]       byte_o;
  logic             byte_valid_o;
  logic             byte_ready_i;
  logic             busy_o;
  logic [9:0]       global_best_o;
  logic [15:0]      frames_sent_o;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [7:0] rx[$];

  best_result_reporter #(.NONCE_BYTES(NB), .HEADER_BYTE(8'hA5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .best_nonce_i(best_nonce_i),
    .best_bits_off_i(best_bits_off_i), .clear_i(clear_i), .byte_o(byte_o),
    .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i), .busy_o(busy_o),
    .global_best_o(global_best_o), .frames_sent_o(frames_sent_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference model: global best, one pending report, and the frame currently on the wire
  logic [9:0]      m_gbest;
  logic            m_pend;
  logic [9:0]      m_sscore;
  logic [8*NB-1:0] m_snonce;
  logic            m_inframe;
  int              m_pos;
  logic [15:0]     m_frames;
  logic [7:0]      m_frame[LEN];
  logic            m_imp;
  logic [7:0]      m_x;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_gbest = 10'h3FF; m_pend = 1'b0; m_inframe = 1'b0; m_pos = 0; m_frames = '0;
    end else begin
      m_imp = best_bits_off_i < m_gbest;
      if (m_inframe) begin
        if (byte_ready_i) begin
          m_pos++;
          if (m_pos == LEN) begin
            m_inframe = 1'b0;
            m_frames  = m_frames + 16'd1;
          end
        end
      end else if (m_pend && !clear_i) begin
        m_frame[0] = 8'hA5;
        m_frame[1] = {6'b0, m_sscore[9:8]};
        m_frame[2] = m_sscore[7:0];
        for (int j = 0; j < NB; j++) m_frame[3+j] = m_snonce[8*(NB-j)-1 -: 8];
`ifdef REPORTER_CHECKSUM_EN
        m_x = 8'h00;
        for (int j = 0; j < LEN-1; j++) m_x = m_x ^ m_frame[j];
        m_frame[LEN-1] = m_x;
`endif
        m_inframe = 1'b1;
        m_pos     = 0;
        m_pend    = 1'b0;
      end
      if (clear_i) begin
        m_gbest = 10'h3FF; m_pend = 1'b0;
      end else if (m_imp) begin
        m_gbest = best_bits_off_i; m_pend = 1'b1;
        m_sscore = best_bits_off_i; m_snonce = best_nonce_i;
      end
    end
  end

  // Every-cycle comparison against the model, plus capture of accepted bytes
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("valid", 32'(byte_valid_o), 32'(m_inframe));
      chk("busy", 32'(busy_o), 32'(m_inframe));
      chk("gbest", 32'(global_best_o), 32'(m_gbest));
      chk("frames", 32'(frames_sent_o), 32'(m_frames));
      if (m_inframe) chk("byte", 32'(byte_o), 32'(m_frame[m_pos]));
      if (byte_valid_o && byte_ready_i && !rst_i) rx.push_back(byte_o);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_rx(input int n, input string nm);
    int b = 0;
    while (!(byte_valid_o && rx.size() == n) && b < 1000) begin step(); b++; end
    if (b >= 1000) begin errors++; $display("FAIL timeout %s rx=%0d exp=%0d", nm, rx.size(), n); end
  endtask

  task automatic wait_frames(input int n);
    int b = 0;
    while (32'(frames_sent_o) != n && b < 1000) begin step(); b++; end
    if (b >= 1000) begin errors++; $display("FAIL timeout frames act=%0d exp=%0d", frames_sent_o, n); end
  endtask

  logic [8*NB-1:0] n0, n1, n2;
  logic [7:0] e;
  int gap;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; byte_ready_i = 1'b1;
    best_bits_off_i = 10'h3FF; best_nonce_i = '0;
    for (int i = 0; i < NB; i++) begin
      n0[8*(NB-i)-1 -: 8] = 8'h11;
      n1[8*(NB-i)-1 -: 8] = 8'(i + 1);
      n2[8*(NB-i)-1 -: 8] = 8'(8'h80 + i);
    end
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_valid", 32'(byte_valid_o), 32'd0);
    chk("rst_byte", 32'(byte_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_gbest", 32'(global_best_o), 32'h3FF);
    chk("rst_frames", 32'(frames_sent_o), 32'd0);
    rst_i = 1'b0;

    // First frame: score 0x12C, nonce bytes 01..20
    best_bits_off_i = 10'h12C; best_nonce_i = n1;
    step();
    chk("gbest_12c", 32'(global_best_o), 32'h12C);
    wait_rx(4, "byte4");
    byte_ready_i = 1'b0;
    repeat (5) begin
      step();
      chk("stall_byte", 32'(byte_o), 32'h02);
      chk("stall_valid", 32'(byte_valid_o), 32'd1);
    end
    byte_ready_i = 1'b1;
    repeat (3) step();

    // Two improvements while the first frame is still on the wire
    best_bits_off_i = 10'h100; best_nonce_i = n0;
    step();
    chk("gbest_100", 32'(global_best_o), 32'h100);
    best_bits_off_i = 10'h0F0; best_nonce_i = n2;
    step();
    chk("gbest_0f0", 32'(global_best_o), 32'h0F0);

    wait_frames(1);
    chk("f1_len", 32'(rx.size()), 32'(LEN));
    for (int i = 0; i < LEN && i < rx.size(); i++) begin
      if (i == 0) e = 8'hA5;
      else if (i == 1) e = 8'h01;
      else if (i == 2) e = 8'h2C;
      else if (i < NB + 3) e = 8'(i - 2);
      else e = 8'hA8;
      chk($sformatf("f1_b%0d", i), 32'(rx[i]), 32'(e));
    end
    gap = 0;
    while (!byte_valid_o && gap < 50) begin gap++; step(); end
    chk("idle_gap", 32'(gap), 32'd1);

    wait_frames(2);
    chk("f2_len", 32'(rx.size()), 32'(2 * LEN));
    if (rx.size() >= LEN + 4) begin
      chk("f2_hdr", 32'(rx[LEN]), 32'hA5);
      chk("f2_shi", 32'(rx[LEN+1]), 32'h00);
      chk("f2_slo", 32'(rx[LEN+2]), 32'hF0);
      chk("f2_n0", 32'(rx[LEN+3]), 32'h80);
    end
    chk("frames_2", 32'(frames_sent_o), 32'd2);

    // Non-improving inputs: no frame, best unchanged
    best_bits_off_i = 10'h12C;
    repeat (2) step();
    best_bits_off_i = 10'h200;
    repeat (4) begin step(); chk("noimp_valid", 32'(byte_valid_o), 32'd0); end
    chk("noimp_gbest", 32'(global_best_o), 32'h0F0);

    // clear wins over a simultaneous improvement
    clear_i = 1'b1; best_bits_off_i = 10'h050;
    step();
    clear_i = 1'b0; best_bits_off_i = 10'h3FF;
    chk("clr_gbest", 32'(global_best_o), 32'h3FF);
    repeat (3) begin step(); chk("clr_valid", 32'(byte_valid_o), 32'd0); end

    // Improvement after clear: best next cycle, header the cycle after
    best_bits_off_i = 10'h050; best_nonce_i = n1;
    step();
    chk("lat_gbest", 32'(global_best_o), 32'h050);
    chk("lat_valid0", 32'(byte_valid_o), 32'd0);
    step();
    chk("lat_valid1", 32'(byte_valid_o), 32'd1);
    chk("lat_hdr", 32'(byte_o), 32'hA5);

    // Reset while byte 10 of this frame is presented
    wait_rx(2 * LEN + 10, "byte10");
    rst_i = 1'b1; best_bits_off_i = 10'h3FF;
    step();
    rst_i = 1'b0;
    chk("mrst_valid", 32'(byte_valid_o), 32'd0);
    chk("mrst_byte", 32'(byte_o), 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_gbest", 32'(global_best_o), 32'h3FF);
    chk("mrst_frames", 32'(frames_sent_o), 32'd0);
    repeat (10) begin step(); chk("mrst_quiet", 32'(byte_valid_o), 32'd0); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/best_result_reporter.md
# best_result_reporter

Downstream of the hashing core: watches the core's running best nonce and bits-off score and keeps a global best. Whenever the score strictly improves, it serializes a framed report (header, score, nonce, optional checksum) onto a byte-wide valid/ready stream. The UART transmitter consumes that stream.

## Interface
Parameters:
- NONCE_BYTES, default 32: nonce width in bytes; the nonce is 8*NONCE_BYTES bits.
- HEADER_BYTE, default 8'hA5: first byte of every frame.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous, active-high reset.
- best_nonce_i  input  8*NONCE_BYTES  best nonce from the core.
- best_bits_off_i  input  10  bits-off score for best_nonce_i; lower is better.
- clear_i  input  1  restarts the search: sets the global best to 10'h3FF and drops any pending report.
- byte_o  output  8  stream data.
- byte_valid_o  output  1  byte_o is valid.
- byte_ready_i  input  1  consumer accepts the byte.
- busy_o  output  1  a frame is in flight.
- global_best_o  output  10  best score seen since reset or clear.
- frames_sent_o  output  16  count of completed frames.

## Operation
- Improvement: best_bits_off_i < global_best_o (strict, unsigned), sampled every cycle.
- On improvement, at the same edge:
  - global_best_o <= best_bits_off_i.
  - The pending snapshot {best_bits_off_i, best_nonce_i} is captured and pending is set.
  - A newer improvement overwrites an older unsent pending snapshot; the pending buffer is one deep.
- FSM states:
  - IDLE: if pending, load the snapshot into the shift register, clear pending (unless a new improvement sets it at the same edge), set byte index = 0, go to SEND.
  - SEND: present the byte at the current index.
    - On byte_valid_o && byte_ready_i: advance the index.
    - After the last byte is accepted: frames_sent_o increments, then go to IDLE.
- Frame byte order:
  - HEADER_BYTE.
  - {6'b0, score[9:8]}.
  - score[7:0].
  - Nonce, most significant byte first (NONCE_BYTES bytes).
  - Checksum byte, if compiled in (see Configuration).
- The snapshot being sent is frozen. Improvements during SEND only update global_best_o and pending.
- clear_i:
  - Sets global_best_o to 10'h3FF and clears pending.
  - Does not abort a frame already in SEND.
  - If clear_i and an improvement occur in the same cycle, clear wins: global best = 3FF, pending = 0.
- Arithmetic:
  - frames_sent_o wraps from 16'hFFFF to 0.
  - The byte index counter is sized for the frame length and is never exceeded.

## Timing
- Reset values:
  - byte_valid_o = 0, byte_o = 0, busy_o = 0.
  - global_best_o = 10'h3FF, frames_sent_o = 0.
  - pending = 0, FSM in IDLE.
- Latency: an improving input present in cycle k gives:
  - global_best_o updated in cycle k+1.
  - byte_valid_o high with the header in cycle k+2, provided the FSM was IDLE in cycle k+1.
- byte_valid_o and byte_o are registered.
- Handshake:
  - While byte_valid_o = 1 and byte_ready_i = 0, byte_o holds stable and byte_valid_o stays high.
  - A new byte follows in the cycle after each accept, so one byte per cycle with ready tied high.
  - byte_valid_o never depends combinationally on byte_ready_i.
- busy_o is 1 from the first cycle byte_valid_o rises until the cycle after the last accept.
- Back-to-back frames: if pending is set when the last byte is accepted, IDLE lasts exactly one cycle before the next header.
- Reset mid-frame: at the reset edge all state returns to reset values; the partial frame is abandoned and byte_valid_o is low in the following cycle.

## Configuration
- REPORTER_CHECKSUM_EN defined:
  - Frame is 3+NONCE_BYTES+1 bytes (36 at the default).
  - The final byte is the XOR of all preceding bytes, header included.
- Not defined:
  - Frame is 3+NONCE_BYTES bytes (35 at the default), with no checksum logic.
  - frames_sent_o increments on the last nonce byte.

## Test plan
- After reset, set best_bits_off_i = 10'h12C, nonce = 256'h01..20 (bytes 01 to 20), ready tied high. Expect:
  - global_best_o = 0x12C one cycle later.
  - Stream A5 01 2C 01 02 … 20, then checksum = XOR of all preceding bytes (when REPORTER_CHECKSUM_EN is defined).
  - frames_sent_o = 1.
- Backpressure: hold ready low for 5 cycles on byte 4. Expect byte_o constant and valid high during the stall, and no byte lost or duplicated.
- Mid-frame improvements of 0x100, then 0x0F0, during SEND. Expect:
  - Only the 0x0F0 frame follows, after exactly one IDLE cycle.
  - global_best_o = 0x0F0.
  - frames_sent_o = 2.
- Non-improving inputs: 0x12C again, then 0x200. Expect no frame and global_best_o unchanged.
- clear_i asserted in the same cycle as an improving input of 0x050 while IDLE. Expect global_best_o = 0x3FF and no frame. Then input 0x050 → a frame is sent.
- rst_i asserted at byte 10 of a frame. Expect byte_valid_o = 0 next cycle, all outputs at reset values, and no further bytes until a new improvement.
